// File: rtl/rca_lsq_if.sv
// Memory-side bus of the load/store queue: one request channel plus a load-return channel.
interface rca_lsq_if #(
  parameter int XLEN = 32
) ();
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_rnw;
  logic            mem_request;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rvalid;

  modport master (
    output mem_addr, mem_wdata, mem_be, mem_rnw, mem_request,
    input  mem_ack, mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_be, mem_rnw, mem_request,
    output mem_ack, mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/rca_lsq.sv
// In-order load/store queue: buffers requests, issues the head entry to memory and
// formats returned load words. Loads block further issue until their data returns.
module rca_lsq #(
  parameter int LSQ_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  input  logic            new_request,
  output logic            lsq_full,
  output logic [XLEN-1:0] load_data,
  output logic            load_complete,
  rca_lsq_if.master       mem
);

  localparam int PW = $clog2(LSQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {ISSUE, WAIT_LOAD} state_t;

  logic [XLEN-1:0] e_addr [LSQ_DEPTH];
  logic [XLEN-1:0] e_data [LSQ_DEPTH];
  logic [2:0]      e_fn3  [LSQ_DEPTH];
  logic            e_load [LSQ_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  state_t        state_q, state_d;
  logic [1:0]    wl_off;
  logic [2:0]    wl_fn3;

  logic [XLEN-1:0] h_addr, h_data;
  logic [2:0]      h_fn3;
  logic            h_load;
  logic            mem_req, enq, deq, rv_take;

  function automatic logic [3:0] be_f(input logic [2:0] f, input logic [1:0] off);
    logic [3:0] be;
    case (f[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] wdata_f(input logic [2:0] f, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    case (f[1:0])
      2'b00:   w = XLEN'({4{d[7:0]}});
      2'b01:   w = XLEN'({2{d[15:0]}});
      default: w = d;
    endcase
    return w;
  endfunction

  // Lane selection ignores misalignment: the aligned half/word is returned as-is.
  function automatic logic [XLEN-1:0] ld_fmt(input logic [2:0] f, input logic [1:0] off,
                                            input logic [XLEN-1:0] w);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign h_addr = e_addr[rd_ptr];
  assign h_data = e_data[rd_ptr];
  assign h_fn3  = e_fn3[rd_ptr];
  assign h_load = e_load[rd_ptr];

  assign lsq_full = (count == CW'(LSQ_DEPTH));
  assign enq      = new_request && !lsq_full && (load != store);
  assign mem_req  = (state_q == ISSUE) && (count != '0);
  assign deq      = mem_req && mem.mem_ack;
  assign rv_take  = (state_q == WAIT_LOAD) && mem.mem_rvalid;

  assign mem.mem_request = mem_req;
  assign mem.mem_addr    = {h_addr[XLEN-1:2], 2'b00};
  assign mem.mem_rnw     = h_load;
  assign mem.mem_be      = h_load ? 4'b1111 : be_f(h_fn3, h_addr[1:0]);
  assign mem.mem_wdata   = wdata_f(h_fn3, h_data);

  // Queue storage and in-flight load context
  always_ff @(posedge clk) begin
    if (enq) begin
      e_addr[wr_ptr] <= addr;
      e_data[wr_ptr] <= data;
      e_fn3[wr_ptr]  <= fn3;
      e_load[wr_ptr] <= load;
    end
    if (deq) begin
      wl_off <= h_addr[1:0];
      wl_fn3 <= h_fn3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      state_q       <= ISSUE;
      load_complete <= 1'b0;
      load_data     <= '0;
    end else begin
      state_q       <= state_d;
      load_complete <= rv_take;
      if (rv_take) load_data <= ld_fmt(wl_fn3, wl_off, mem.mem_rdata);
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISSUE:     if (deq && h_load) state_d = WAIT_LOAD;
      WAIT_LOAD: if (mem.mem_rvalid) state_d = ISSUE;
      default:   state_d = ISSUE;
    endcase
  end

endmodule

// File: tb/tb_rca_lsq.sv
// Bench for rca_lsq: vector table through a scoreboard, then queue-full, ordering and reset corners.
module tb_rca_lsq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0, data = '0;
  logic [2:0]  fn3 = '0;
  logic        load = 1'b0, store = 1'b0, new_request = 1'b0;
  logic        lsq_full, load_complete;
  logic [31:0] load_data;

  rca_lsq_if #(.XLEN(32)) bus ();

  rca_lsq #(.LSQ_DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .fn3(fn3),
    .load(load), .store(store), .new_request(new_request),
    .lsq_full(lsq_full), .load_data(load_data), .load_complete(load_complete),
    .mem(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  fn3;
    logic        ld;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_ldata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rnw;
    logic [31:0] rdata;
    logic [31:0] ldata;
  } exp_t;

  exp_t sb[$];
  vec_t vt[12];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mkv(logic [31:0] a, logic [31:0] d, logic [2:0] f, logic ld,
                               logic [31:0] rd, logic [31:0] ea, logic [3:0] eb,
                               logic [31:0] ew, logic [31:0] el);
    vec_t v;
    v.addr = a; v.data = d; v.fn3 = f; v.ld = ld; v.rdata = rd;
    v.e_addr = ea; v.e_be = eb; v.e_wdata = ew; v.e_ldata = el;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [3:0] be, input logic [31:0] w,
                          input logic rnw, input logic [31:0] rd, input logic [31:0] ld);
    exp_t e;
    e.addr = a; e.be = be; e.wdata = w; e.rnw = rnw; e.rdata = rd; e.ldata = ld;
    sb.push_back(e);
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                     input logic ld, input logic st);
    addr = a; data = d; fn3 = f; load = ld; store = st; new_request = 1'b1;
    @(negedge clk);
    new_request = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    for (int i = 0; i < 30; i++) begin
      if (bus.mem_request) return;
      @(negedge clk);
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s: mem_request timeout, got 0, expected 1", nm);
  endtask

  // Pops the head expectation, checks the presented request, acks it and serves loads.
  task automatic issue_check(input string nm, input int rv_delay);
    exp_t e;
    wait_req(nm);
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty, got request, expected none", nm);
      return;
    end
    e = sb.pop_front();
    chk({nm, ".req"},  {31'd0, bus.mem_request}, 32'd1);
    chk({nm, ".addr"}, bus.mem_addr, e.addr);
    chk({nm, ".be"},   {28'd0, bus.mem_be}, {28'd0, e.be});
    chk({nm, ".rnw"},  {31'd0, bus.mem_rnw}, {31'd0, e.rnw});
    if (!e.rnw) chk({nm, ".wdata"}, bus.mem_wdata, e.wdata);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    if (e.rnw) begin
      for (int i = 0; i <= rv_delay; i++) begin
        chk({nm, ".wait_noreq"}, {31'd0, bus.mem_request}, 32'd0);
        if (i < rv_delay) @(negedge clk);
      end
      bus.mem_rdata  = e.rdata;
      bus.mem_rvalid = 1'b1;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      chk({nm, ".lc"},    {31'd0, load_complete}, 32'd1);
      chk({nm, ".ldata"}, load_data, e.ldata);
      @(negedge clk);
      chk({nm, ".lc_pulse"}, {31'd0, load_complete}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    vt[0]  = mkv(32'h0000_1003, 32'h0000_00AB, 3'b000, 1'b0, 32'h0, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0);
    vt[1]  = mkv(32'h0000_2002, 32'h1234_BEEF, 3'b001, 1'b0, 32'h0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    vt[2]  = mkv(32'h0000_3000, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0, 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    vt[3]  = mkv(32'h0000_2003, 32'h0000_5555, 3'b001, 1'b0, 32'h0, 32'h0000_2000, 4'b1100, 32'h5555_5555, 32'h0);
    vt[4]  = mkv(32'h0000_2001, 32'h0, 3'b000, 1'b1, 32'h0000_8000, 32'h0000_2000, 4'b1111, 32'h0, 32'hFFFF_FF80);
    vt[5]  = mkv(32'h0000_2001, 32'h0, 3'b100, 1'b1, 32'h0000_8000, 32'h0000_2000, 4'b1111, 32'h0, 32'h0000_0080);
    vt[6]  = mkv(32'h0000_4002, 32'h0, 3'b001, 1'b1, 32'h8001_1234, 32'h0000_4000, 4'b1111, 32'h0, 32'hFFFF_8001);
    vt[7]  = mkv(32'h0000_4002, 32'h0, 3'b101, 1'b1, 32'h8001_1234, 32'h0000_4000, 4'b1111, 32'h0, 32'h0000_8001);
    vt[8]  = mkv(32'h0000_5004, 32'h0, 3'b010, 1'b1, 32'hCAFE_F00D, 32'h0000_5004, 4'b1111, 32'h0, 32'hCAFE_F00D);
    vt[9]  = mkv(32'h0000_6000, 32'h0, 3'b000, 1'b1, 32'h1234_567F, 32'h0000_6000, 4'b1111, 32'h0, 32'h0000_007F);
    vt[10] = mkv(32'h0000_7002, 32'h0, 3'b010, 1'b1, 32'h1122_3344, 32'h0000_7000, 4'b1111, 32'h0, 32'h1122_3344);
    vt[11] = mkv(32'h0000_8001, 32'h0, 3'b001, 1'b1, 32'hAAAA_7FFF, 32'h0000_8000, 4'b1111, 32'h0, 32'h0000_7FFF);

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.full", {31'd0, lsq_full}, 32'd0);
    chk("rst.req",  {31'd0, bus.mem_request}, 32'd0);
    chk("rst.lc",   {31'd0, load_complete}, 32'd0);
    chk("rst.ldata", load_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      push_exp(vt[i].e_addr, vt[i].e_be, vt[i].e_wdata, vt[i].ld, vt[i].rdata, vt[i].e_ldata);
      enq(vt[i].addr, vt[i].data, vt[i].fn3, vt[i].ld, !vt[i].ld);
      issue_check($sformatf("vec%0d", i), 0);
    end

    // load==store requests are dropped
    enq(32'h9000, 32'h1, 3'b010, 1'b1, 1'b1);
    enq(32'h9004, 32'h1, 3'b010, 1'b0, 1'b0);
    @(negedge clk);
    chk("drop.req", {31'd0, bus.mem_request}, 32'd0);

    // Five stores with no ack: fourth fills the queue, fifth dropped
    for (int i = 0; i < 5; i++) begin
      a = 32'h100 + 32'(i * 4);
      if (i == 4) chk("fill.full", {31'd0, lsq_full}, 32'd1);
      if (i < 4) push_exp(a, 4'b1111, a ^ 32'h5A5A_0000, 1'b0, 32'h0, 32'h0);
      enq(a, a ^ 32'h5A5A_0000, 3'b010, 1'b0, 1'b1);
    end
    repeat (2) @(negedge clk);
    chk("stall.addr",  bus.mem_addr, sb[0].addr);
    chk("stall.wdata", bus.mem_wdata, sb[0].wdata);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("order%0d.req", k), {31'd0, bus.mem_request}, 32'd1);
      chk($sformatf("order%0d.addr", k), bus.mem_addr, e.addr);
      bus.mem_ack = 1'b1;
      @(negedge clk);
      if (k == 0) chk("ack1.full", {31'd0, lsq_full}, 32'd0);
    end
    bus.mem_ack = 1'b0;
    chk("fifth.dropped", {31'd0, bus.mem_request}, 32'd0);

    // Full queue: simultaneous ack and new_request leaves three entries
    for (int i = 0; i < 4; i++) begin
      a = 32'h200 + 32'(i * 4);
      push_exp(a, 4'b1111, a, 1'b0, 32'h0, 32'h0);
      enq(a, a, 3'b010, 1'b0, 1'b1);
    end
    chk("full2.full", {31'd0, lsq_full}, 32'd1);
    begin
      exp_t e;
      e = sb.pop_front();
      chk("full2.head", bus.mem_addr, e.addr);
    end
    bus.mem_ack = 1'b1;
    addr = 32'h2F0; data = 32'h2F0; fn3 = 3'b010; load = 1'b0; store = 1'b1; new_request = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0; new_request = 1'b0;
    chk("full2.notfull", {31'd0, lsq_full}, 32'd0);
    for (int i = 0; i < 3; i++) issue_check($sformatf("drain%0d", i), 0);
    chk("full2.count3", {31'd0, bus.mem_request}, 32'd0);

    // Load then store: store held until load data returns
    push_exp(32'h300, 4'b1111, 32'h0, 1'b1, 32'h1234_5678, 32'h1234_5678);
    push_exp(32'h304, 4'b1111, 32'h0BAD_F00D, 1'b0, 32'h0, 32'h0);
    enq(32'h300, 32'h0, 3'b010, 1'b1, 1'b0);
    enq(32'h304, 32'h0BAD_F00D, 3'b010, 1'b0, 1'b1);
    issue_check("ldst.load", 3);
    chk("ldst.store_ready", {31'd0, bus.mem_request}, 32'd1);
    issue_check("ldst.store", 0);

    // Stray rvalid while idle
    bus.mem_rdata = 32'hFFFF_FFFF; bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("stray.lc", {31'd0, load_complete}, 32'd0);
    chk("stray.ldata", load_data, 32'h1234_5678);

    // Reset during WAIT_LOAD
    enq(32'h400, 32'h0, 3'b010, 1'b1, 1'b0);
    wait_req("rstwl");
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rstwl.req",   {31'd0, bus.mem_request}, 32'd0);
    chk("rstwl.full",  {31'd0, lsq_full}, 32'd0);
    chk("rstwl.ldata", load_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    bus.mem_rdata = 32'h7777_7777; bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("rstwl.lc", {31'd0, load_complete}, 32'd0);
    @(negedge clk);
    chk("rstwl.lc2", {31'd0, load_complete}, 32'd0);
    chk("rstwl.req2", {31'd0, bus.mem_request}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rca_lsq.md
RCA_LSQ -- requirements
Module: rca_lsq

Interface
REQ-001 Parameter LSQ_DEPTH, default 4, queue entry count; power of two, >=2.
REQ-002 Parameter XLEN, default 32, data/address width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 addr  in  XLEN  request byte address from operation unit.
REQ-006 data  in  XLEN  store data, right-aligned.
REQ-007 fn3  in  3  access size/sign: LB=000, LH=001, LW=010, LBU=100, LHU=101; stores use 000/001/010.
REQ-008 load  in  1  request is a load.
REQ-009 store  in  1  request is a store.
REQ-010 new_request  in  1  enqueue strobe.
REQ-011 lsq_full  out  1  queue cannot accept; new_request ignored while high.
REQ-012 load_data  out  XLEN  formatted load result.
REQ-013 load_complete  out  1  one-cycle pulse; load_data valid.
REQ-014 mem_addr  out  XLEN  word-aligned address (addr[1:0] forced 0).
REQ-015 mem_wdata  out  XLEN  byte-lane-replicated store data.
REQ-016 mem_be  out  4  byte enables (stores); 4'b1111 for loads.
REQ-017 mem_rnw  out  1  1 = read, 0 = write.
REQ-018 mem_request  out  1  head entry presented to memory.
REQ-019 mem_ack  in  1  memory accepts request this cycle.
REQ-020 mem_rdata  in  XLEN  raw word returned for a load.
REQ-021 mem_rvalid  in  1  mem_rdata valid.

Function
REQ-022 Enqueue occurs when new_request && !lsq_full; entry stores addr, data, fn3, load; request with load==store is dropped.
REQ-023 lsq_full SHALL equal (count == LSQ_DEPTH), from registered count; simultaneous dequeue does not lower it in the same cycle.
REQ-024 Entries issue strictly in FIFO order; read/write pointers wrap modulo LSQ_DEPTH.
REQ-025 FSM states ISSUE and WAIT_LOAD; mem_request = (state==ISSUE) && count!=0.
REQ-026 Dequeue on mem_request && mem_ack; store entry stays in ISSUE; load entry transitions to WAIT_LOAD.
REQ-027 In WAIT_LOAD no request issues; on mem_rvalid: return to ISSUE, register formatted data, pulse load_complete next cycle.
REQ-028 Enqueue and dequeue in the same cycle leave count unchanged.
REQ-029 mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-030 mem_wdata: byte {4{data[7:0]}}; half {2{data[15:0]}}; word data.
REQ-031 Load formatting: select byte/half by entry addr[1:0]/addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW pass-through.
REQ-032 Misaligned half/word accesses use the aligned lane; no exception generated.
REQ-033 mem_rvalid outside WAIT_LOAD is ignored.
REQ-034 Head-entry outputs remain stable while mem_request is high and mem_ack low.

Reset
REQ-035 Reset SHALL clear pointers and count, force state ISSUE, and drive lsq_full=0, mem_request=0, load_complete=0, load_data=0; entry contents are don't-care.
REQ-036 Reset asserted mid-operation (including WAIT_LOAD) discards all entries; no load_complete after release.

Verification
REQ-037 Store SB addr=0x1003 data=0xAB -> mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xABABABAB, mem_rnw=0.
REQ-038 Load LB addr=0x2001, mem_rdata=0x0000_8000 -> load_data=0xFFFF_FF80, load_complete one cycle after mem_rvalid; LBU same -> 0x0000_0080.
REQ-039 Five stores with mem_ack=0, LSQ_DEPTH=4 -> lsq_full high after fourth enqueue, fifth dropped; ack four times -> four writes in order, lsq_full low after first ack.
REQ-040 Load then store queued -> store not issued until mem_rvalid for load arrives.
REQ-041 Full queue, simultaneous ack and new_request -> new_request ignored, count 3.
REQ-042 rst low during WAIT_LOAD, then mem_rvalid -> no load_complete, mem_request=0, lsq_full=0.
